// File: rtl/ms_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter with saturation at 10^DIGITS-1.
// Latency is BIN_W cycles from the accepted start to done; a start is accepted only in IDLE and is otherwise dropped.
module ms_bcd_converter #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      value,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam longint unsigned LIMIT     = pow10(DIGITS) - 64'd1;
    localparam logic [BIN_W-1:0] LIMIT_BIN = BIN_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST_IT   = CNT_W'(BIN_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   bin_q, bin_nxt;
    logic [SCR_W-1:0]   scr_q, scr_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               pend_q, pend_nxt;
    logic [SCR_W-1:0]   bcd_q, bcd_nxt;
    logic               ovf_q, ovf_nxt;
    logic               done_q, done_nxt;
    logic               sat;
    logic [SCR_W-1:0]   adj;

    // Digits are corrected independently; no carry ever crosses a nibble.
    function automatic logic [SCR_W-1:0] add3(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] r;
        logic [3:0]       d;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            d = s[4*i +: 4];
            if (d >= 4'd5) begin
                r[4*i +: 4] = d + 4'd3;
            end
        end
        return r;
    endfunction

    assign sat = (64'(value) > LIMIT);
    assign adj = add3(scr_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            bin_q  <= '0;
            scr_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            bin_q  <= bin_nxt;
            scr_q  <= scr_nxt;
            cnt_q  <= cnt_nxt;
            pend_q <= pend_nxt;
            bcd_q  <= bcd_nxt;
            ovf_q  <= ovf_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bin_nxt   = bin_q;
        scr_nxt   = scr_q;
        cnt_nxt   = cnt_q;
        pend_nxt  = pend_q;
        bcd_nxt   = bcd_q;
        ovf_nxt   = ovf_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    bin_nxt   = sat ? LIMIT_BIN : value;
                    pend_nxt  = sat;
                    scr_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                {scr_nxt, bin_nxt} = {adj[SCR_W-2:0], bin_q, 1'b0};
                cnt_nxt = cnt_q + 1'b1;
                // Final iteration publishes the post-shift scratch directly.
                if (cnt_q == LAST_IT) begin
                    bcd_nxt   = {adj[SCR_W-2:0], bin_q[BIN_W-1]};
                    ovf_nxt   = pend_q;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state == SHIFT);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ms_bcd_converter.sv
// Randomized bench for ms_bcd_converter against a decimal-arithmetic reference model.
module tb_ms_bcd_converter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] value = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    ms_bcd_converter #(.BIN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic ref_ovf(input int v);
        return v > 9999;
    endfunction

    // Called right after start is raised on a falling edge; lat counts edges from the accepting edge to done.
    task automatic wait_done(input bit hold, input int poke_at,
                             output int lat, output int busy_cyc, output int overlap);
        lat = -1;
        busy_cyc = 0;
        overlap = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!hold && k == 1) start = 1'b0;
            if (k == poke_at) begin
                start = 1'b1;
                value = 14'd42;
            end else if (k == poke_at + 1) begin
                start = 1'b0;
            end
            if (busy) busy_cyc++;
            if (busy && done) overlap++;
            if (done) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    task automatic convert(input int v, input string tag);
        int lat, bc, ov;
        @(negedge clk);
        value = 14'(v);
        start = 1'b1;
        wait_done(1'b0, -5, lat, bc, ov);
        chk({tag, " latency"}, 32'(lat), 32'd14);
        chk({tag, " busy cycles"}, 32'(bc), 32'd14);
        chk({tag, " busy&done"}, 32'(ov), 32'd0);
        chk({tag, " bcd"}, 32'(bcd), 32'(ref_bcd(v)));
        chk({tag, " overflow"}, 32'(overflow), 32'(ref_ovf(v)));
        @(negedge clk);
        chk({tag, " done pulse width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, bc, ov, bad, dones, last_k, gap_bad, v;
        int dk[$];

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset bcd", 32'(bcd), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        convert(0, "zero");
        convert(1234, "v1234");
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bcd !== 16'h1234 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("hold 1234 idle", 32'(bad), 32'd0);
        convert(9999, "v9999");
        convert(10000, "v10000");
        convert(16383, "v16383");
        for (int i = 0; i < 20; i++) begin
            v = (i % 4 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
            convert(v, $sformatf("rand%0d_%0d", i, v));
        end

        // Restart attempt mid-conversion must be ignored.
        @(negedge clk);
        value = 14'd567;
        start = 1'b1;
        wait_done(1'b0, 5, lat, bc, ov);
        chk("ignore latency", 32'(lat), 32'd14);
        chk("ignore bcd", 32'(bcd), 32'h0567);
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("ignore no second conv", 32'(dones), 32'd0);

        // Start held high: back-to-back conversions every 15 cycles.
        @(negedge clk);
        value = 14'd250;
        start = 1'b1;
        bad = 0;
        gap_bad = 0;
        last_k = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy && done) bad++;
            if (done) begin
                if (bcd !== 16'h0250 || overflow !== 1'b0) bad++;
                if (k - last_k != 15) gap_bad++;
                last_k = k;
                dk.push_back(k);
            end
        end
        start = 1'b0;
        chk("held done count", 32'(dk.size()), 32'd4);
        chk("held gap", 32'(gap_bad), 32'd0);
        chk("held result", 32'(bad), 32'd0);
        repeat (20) @(negedge clk);

        // Reset mid-conversion aborts without a done pulse.
        value = 14'd8765;
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        chk("pre-reset busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort bcd", 32'(bcd), 32'd0);
        chk("abort overflow", 32'(overflow), 32'd0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("abort no done", 32'(dones), 32'd0);
        convert(31, "after abort 31");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
